// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a one-cycle turnaround between grants.
// Each grant is held until the owner drops req, done is asserted, or the grant reaches MAX_HOLD cycles.
module rr_arbiter_4 #(
   parameter int unsigned MAX_HOLD = 8   // legal range 1..15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       busy
);

   // state | meaning
   // IDLE  | no owner; choose one from req, starting the search at ptr
   // GRANT | grant_idx owns the resource; hold_cnt counts visible cycles minus one
   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   state_t     state, state_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [3:0] hold_cnt, hold_nxt;
   logic [1:0] idx_nxt;
   logic [1:0] pick, cand;
   logic       found;
   logic       release_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         hold_cnt  <= 4'd0;
         grant_idx <= 2'd0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= hold_nxt;
         grant_idx <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      hold_nxt    = hold_cnt;
      idx_nxt     = grant_idx;
      pick        = ptr;
      cand        = ptr;
      found       = 1'b0;
      release_now = 1'b0;

      // Walk the search order backwards so the closest requester to ptr wins.
      for (int k = 3; k >= 0; k--) begin
         cand = ptr + 2'(k);
         if (req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end

      case (state)
         IDLE: begin
            if (found) begin
               idx_nxt   = pick;
               hold_nxt  = 4'd0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            hold_nxt    = hold_cnt + 4'd1;
            release_now = !req[grant_idx] || done || (hold_cnt == HOLD_LAST);
            if (release_now) begin
               state_nxt = IDLE;
               ptr_nxt   = grant_idx + 2'd1;
               hold_nxt  = 4'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode registered state only; req and done never reach them combinationally.
   assign busy  = (state == GRANT);
   assign grant = busy ? (4'b0001 << grant_idx) : 4'b0000;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: a reference model predicts every cycle's outputs into a queue,
// which is popped and compared after each rising edge; directed scenarios add sequence checks.
module tb_rr_arbiter_4;

   localparam int MH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       done = 1'b0;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: active flag, owner, next search start, visible-cycle age
   int m_active = 0;
   int m_owner  = 0;
   int m_ptr    = 0;
   int m_age    = 0;

   logic [6:0] exp_q[$];
   logic [3:0] last_grant;
   logic [1:0] last_idx;
   logic [3:0] seq[0:9];

   rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .grant     (grant),
      .grant_idx (grant_idx),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, predict the post-edge outputs, then compare after the edge.
   task automatic step(input logic [3:0] r, input logic d, input logic rs);
      logic [6:0] e;
      logic [3:0] eg;
      int         found;
      req  = r;
      done = d;
      rst  = rs;
      if (rs) begin
         m_active = 0; m_owner = 0; m_ptr = 0; m_age = 0;
      end else if (m_active == 0) begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (found == 0 && r[c]) begin
               found   = 1;
               m_owner = c;
            end
         end
         if (found != 0) begin
            m_active = 1;
            m_age    = 1;
         end
      end else begin
         if (!r[m_owner] || d || m_age == MH) begin
            m_active = 0;
            m_ptr    = (m_owner + 1) % 4;
         end else begin
            m_age++;
         end
      end
      eg = (m_active != 0) ? (4'b0001 << m_owner) : 4'b0000;
      exp_q.push_back({eg, 2'(m_owner), (m_active != 0)});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("queue_empty", 1, 0);
      end else begin
         e = exp_q.pop_front();
         check("grant", grant, e[6:3]);
         check("grant_idx", grant_idx, e[2:1]);
         check("busy", busy, e[0]);
         check("busy_eq_or", busy, |grant);
      end
      last_grant = grant;
      last_idx   = grant_idx;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) step(4'b0000, 1'b0, 1'b1);
   endtask

   initial begin
      int run;

      // Reset with a request present: outputs stay at reset values while rst is high.
      for (int i = 0; i < 3; i++) begin
         step(4'b0001, 1'b0, 1'b1);
         check("rst_grant", last_grant, 4'b0000);
      end
      step(4'b0001, 1'b0, 1'b0);
      check("first_grant", last_grant, 4'b0001);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);

      // All requesting, done pulsed in each grant: strict rotation with idle gaps.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(4'b1111, (m_active != 0), 1'b0);
         seq[i] = last_grant;
      end
      check("rot0", seq[0], 4'b0001);
      check("rot1", seq[1], 4'b0000);
      check("rot2", seq[2], 4'b0010);
      check("rot3", seq[3], 4'b0000);
      check("rot4", seq[4], 4'b0100);
      check("rot5", seq[5], 4'b0000);
      check("rot6", seq[6], 4'b1000);
      check("rot7", seq[7], 4'b0000);
      check("rot8", seq[8], 4'b0001);

      // Hold limit: a lone requester keeps the grant for exactly MAX_HOLD cycles.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(4'b0100, 1'b0, 1'b0);
         seq[i] = last_grant;
      end
      run = 0;
      for (int i = 0; i < 10; i++) begin
         if (seq[i] == 4'b0100 && run == i) run++;
      end
      check("hold_len", run, MH);
      check("hold_gap", seq[8], 4'b0000);
      check("hold_regrant", seq[9], 4'b0100);

      // After requester 1 releases, search starts at 2 so requester 0 wins over 1.
      do_reset();
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0011, 1'b0, 1'b0);
      check("ptr2_grant", last_grant, 4'b0001);
      check("ptr2_idx", last_idx, 2'd0);

      // Reset mid-grant, then recovery.
      do_reset();
      step(4'b1000, 1'b0, 1'b0);
      step(4'b1000, 1'b0, 1'b1);
      check("midrst_grant", last_grant, 4'b0000);
      step(4'b1000, 1'b0, 1'b1);
      step(4'b1000, 1'b0, 1'b0);
      check("postrst_grant", last_grant, 4'b1000);
      check("postrst_idx", last_idx, 2'd3);

      // Owner drops req together with done: a single release, ptr moves to 3.
      do_reset();
      step(4'b0100, 1'b0, 1'b0);
      step(4'b1001, 1'b1, 1'b0);
      check("dual_rel_gap", last_grant, 4'b0000);
      step(4'b1001, 1'b0, 1'b0);
      check("dual_rel_next", last_idx, 2'd3);
      step(4'b1001, 1'b1, 1'b0);
      step(4'b1001, 1'b0, 1'b0);
      check("dual_rel_after", last_idx, 2'd0);

      // Random traffic including done in idle and occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 39) == 0));
      end

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-way round-robin arbiter that shares one datapath resource between four requesters. Each cycle it holds at most one grant, presented both as a 2-bit index and as a one-hot vector. The one-hot vector uses the standard 2-to-4 decode: bit i is set iff grant_idx == i and a grant is active. Grants are held until the owner releases, the resource signals done, or a hold limit expires. A single idle turnaround cycle separates consecutive grants.

## Interface
Parameters:
- MAX_HOLD, default 8: maximum number of consecutive cycles one grant may be held. Legal range 1..15; the hold counter is 4 bits.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- req  input  [3:0]  request lines; req[i] high = requester i wants the resource
- done  input  1  resource finished current transaction; releases the active grant
- grant  output  [3:0]  one-hot grant; 4'b0000 when no grant is active
- grant_idx  output  [1:0]  index of the current or most recent owner
- busy  output  1  high while a grant is active (equals |grant)

## Operation
- State: FSM {IDLE, GRANT}, 2-bit priority pointer ptr, 4-bit hold_cnt, registered grant_idx.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select the first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load grant_idx <= i, hold_cnt <= 0, and go to GRANT.
- GRANT:
  - grant = decode(grant_idx); busy = 1.
  - hold_cnt increments each cycle.
  - Release when any of these holds at a rising edge:
    - req[grant_idx] == 0
    - done == 1
    - hold_cnt == MAX_HOLD-1, i.e. the grant has been visible for MAX_HOLD cycles
  - On release: state <= IDLE, ptr <= grant_idx+1 (3 wraps to 0), hold_cnt <= 0.
- Several release conditions true in the same cycle count as one release; ptr advances exactly once.
- Requests from other requesters arriving during GRANT are ignored until the next IDLE evaluation. There is no preemption.
- grant_idx keeps its last value in IDLE. Consumers qualify it with busy.
- done asserted in IDLE is ignored.
- grant, busy and grant_idx are driven directly from registered state. No combinational path runs from req or done to any output.

## Timing
- Reset (rst high at an edge): state=IDLE, ptr=0, hold_cnt=0, grant=4'b0000, grant_idx=2'b00, busy=0.
  - Applies from the cycle after the edge, including mid-grant.
  - Outputs stay at reset values while rst is held.
- Grant latency: req sampled at edge N in IDLE produces grant visible from edge N+1.
- Release latency: a release condition sampled at edge k drives grant to 0 from edge k+1.
  - The earliest next grant is visible from edge k+2. This is a one-cycle turnaround and is guaranteed for every handover, including re-grant to the same requester.
- Maximum grant width: MAX_HOLD cycles. With MAX_HOLD=1 a grant lasts exactly one cycle.
- Worst-case wait for a continuously asserting requester: 3×(MAX_HOLD+1) cycles after its request is first sampled in IDLE.
- Starvation-free: a requester that holds req high is granted within four arbitration rounds.

## Test plan
- Reset, then req=4'b0001 -> grant=4'b0001, grant_idx=0, busy=1 one cycle after req is sampled. All outputs are 0 during reset.
- req=4'b1111 held, done pulsed for one cycle in each grant -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- MAX_HOLD=8, req=4'b0100 held, done=0 -> grant=0100 for exactly 8 cycles, then 0000 for 1 cycle, then 0100 again.
- After requester 1 is released (ptr=2), req=4'b0011 -> grant=0001. Requester 0 wins because the search order is 2, 3, 0, 1.
- rst pulsed mid-grant with req=4'b1000 held -> grant=0000 from the cycle after the reset edge. After rst drops, grant=1000 one cycle later and grant_idx=3.
- Owner drops req and done=1 in the same cycle -> single release, one idle cycle, ptr advances by one. Verify the next owner matches this.
